// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_align load/store alignment unit.
// Holds the FSM state type, the Funct3 encodings and the access size/alignment rules.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC1,
    S_ACC2,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b01:   return addr_lo == 2'b11;
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic load_legal(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic store_legal(input logic [2:0] funct3);
    case (funct3)
      F3_SB, F3_SH, F3_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_load_extend.sv
// Selects the addressed bytes from a two-word {hi,lo} window and sign/zero-extends
// them according to the load Funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] win,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rd
);

  logic [31:0] w;

  always_comb begin
    w = win[{off, 3'b000} +: 32];
    case (funct3)
      F3_LB:   rd = {{24{w[7]}}, w[7:0]};
      F3_LH:   rd = {{16{w[15]}}, w[15:0]};
      F3_LBU:  rd = {24'h000000, w[7:0]};
      F3_LHU:  rd = {16'h0000, w[15:0]};
      default: rd = w;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns byte-addressed loads/stores into one or two
// word accesses with lane enables. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned requests.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t            state;
  logic                  load_q;
  logic                  split_q;
  logic                  err_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wd_q;
  logic [DATA_W-1:0]     lo_buf;
  logic [DATA_W-1:0]     rd_q;
  logic [2:0]            f3_q;

  logic                  accept;
  logic                  illegal_in;
  logic                  mis_in;
  logic                  bad_in;
  logic [DM_ADDRESS-1:0] lo_addr;
  logic [DM_ADDRESS-1:0] hi_addr;
  logic [3:0]            lanes;
  logic [7:0]            lane_mask;
  logic [63:0]           dbl;
  logic [5:0]            rot_base;
  logic [31:0]           rot;
  logic [63:0]           win;
  logic [31:0]           ext_rd;

  assign accept     = req_valid & (MemRead | MemWrite);
  assign illegal_in = MemRead ? ~load_legal(Funct3) : ~store_legal(Funct3);
  assign mis_in     = misaligned(addr[1:0], Funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_in = illegal_in | mis_in;
`else
  assign bad_in = illegal_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      load_q  <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      lo_buf  <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            load_q  <= MemRead;
            addr_q  <= addr;
            wd_q    <= wd;
            f3_q    <= Funct3;
            split_q <= mis_in & ~bad_in;
            err_q   <= bad_in;
            rd_q    <= '0;
            state   <= bad_in ? S_RESP : S_ACC1;
          end
        end
        S_ACC1: state <= split_q ? S_ACC2 : S_WAIT;
        S_ACC2: begin
          lo_buf <= mem_rdata;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (load_q) rd_q <= ext_rd;
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The high word of a split access wraps to address 0 at the top of memory.
  assign lo_addr = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign hi_addr = lo_addr + {{(DM_ADDRESS-3){1'b0}}, 3'b100};

  // Store data is rotated so byte k of wd lands in lane (o+k) mod 4 of either access.
  assign dbl      = {wd_q, wd_q};
  assign rot_base = 6'd32 - {1'b0, addr_q[1:0], 3'b000};
  assign rot      = dbl[rot_base +: 32];

  always_comb begin
    case (size_of(f3_q))
      3'd1:    lanes = 4'b0001;
      3'd2:    lanes = 4'b0011;
      default: lanes = 4'b1111;
    endcase
    lane_mask = {4'b0000, lanes} << addr_q[1:0];
  end

  always_comb begin
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 4'b0000;
    mem_wd   = '0;
    case (state)
      S_ACC1: begin
        mem_addr = lo_addr;
        mem_re   = load_q;
        mem_we   = load_q ? 4'b0000 : lane_mask[3:0];
        mem_wd   = load_q ? '0 : rot;
      end
      S_ACC2: begin
        mem_addr = hi_addr;
        mem_re   = load_q;
        mem_we   = load_q ? 4'b0000 : lane_mask[7:4];
        mem_wd   = load_q ? '0 : rot;
      end
      default: ;
    endcase
  end

  assign win = split_q ? {mem_rdata, lo_buf} : {32'h0000_0000, mem_rdata};

  load_extend u_load_extend (
    .win    (win),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .rd     (ext_rd)
  );

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign stall     = ((state == S_IDLE) & accept) |
                     (state == S_ACC1) | (state == S_ACC2) | (state == S_WAIT);
  assign rd        = rd_q;
  assign err       = err_q;

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the EX/MEM pipeline register and the word-organised data memory.
- Converts the byte address, Funct3 and store data into word-aligned accesses with byte-lane enables.
- Splits misaligned LW/LH/SW/SH into two word accesses.
- Extracts and sign/zero-extends load data, and stalls the pipeline while busy.

Parameters:
- DM_ADDRESS, 9, byte-address width of data memory.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present from the EX/MEM register.
- MemRead  in  1  load request (control unit).
- MemWrite  in  1  store request (control unit).
- addr  in  DM_ADDRESS  byte address (ALU result LSBs).
- wd  in  DATA_W  store data (rs2).
- Funct3  in  3  instruction bits 14:12.
- req_ready  out  1  high only in IDLE.
- stall  out  1  freeze upstream pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rd  out  DATA_W  extended load data; 0 for stores.
- err  out  1  qualified by rsp_valid: illegal Funct3 (or trapped misalign).
- mem_addr  out  DM_ADDRESS  word-aligned byte address; bits [1:0] are always 0.
- mem_re  out  1  memory read strobe.
- mem_we  out  4  byte-lane write enables; bit i is byte i (little-endian).
- mem_wd  out  DATA_W  lane-shifted store data.
- mem_rdata  in  DATA_W  word read data, valid exactly 1 cycle after mem_re.

Behaviour:
- Reset, and the effect of every reset edge:
  - All outputs become 0 and state becomes IDLE.
  - Any in-flight request is dropped, with no rsp_valid.
  - mem_re and mem_we are 0 in the cycle after the reset edge.
- FSM states: IDLE, ACC1, ACC2, WAIT, RESP. All outputs are driven from registered state and latched request.
- IDLE:
  - Accept when req_valid & (MemRead | MemWrite). Latch addr, wd, Funct3, op, and split = misaligned.
  - MemRead has priority when both MemRead and MemWrite are set.
  - Illegal Funct3 (loads 011/110/111; stores other than 000/001/010): go directly to RESP with err=1, no memory access.
- ACC1: drive the low word (addr & ~3). Next state is ACC2 if split, else WAIT.
- ACC2:
  - Drive the high word (low + 4, modulo 2^DM_ADDRESS, so it wraps to 0 at the top).
  - Capture mem_rdata into lo_buf.
  - Next state WAIT.
- WAIT: assemble rd from lo_buf/mem_rdata (loads), register it, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Latency from accept edge to rsp_valid:
  - aligned: 3 cycles;
  - split: 4 cycles;
  - illegal: 1 cycle.
- stall = (req_valid & state==IDLE & accept) | (state ∉ {IDLE, RESP}). It is low in the rsp_valid cycle.
- Misaligned conditions:
  - word access: addr[1:0] != 0;
  - halfword access: addr[1:0] == 3;
  - byte access: never misaligned.
- Store lanes, with o = addr[1:0]:
  - SB: mem_we = 1<<o, and wd[7:0] is replicated to the selected lane.
  - SH aligned: mem_we = 0011<<o.
  - SW aligned: mem_we = 1111.
  - Split stores: the low access enables lanes o..3; the high access enables the remaining lanes 0..(o+size-5). Data is rotated left by 8*o.
- Load extraction:
  - LB and LH sign-extend to 32 bits (24 or 16 copies of the MSB).
  - LBU and LHU zero-extend.
  - LW returns the raw (assembled) word.
- mem_we = 0 in every state except a store's ACC1/ACC2. mem_re is high only in a load's ACC1/ACC2.
- req_valid with neither MemRead nor MemWrite: ignored, stall stays low.
- Inputs are ignored while not in IDLE. The latched copy is used throughout.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined: misaligned requests make no memory access, go directly to RESP with err=1 and rd=0 (latency 1). Illegal Funct3 handling is unchanged.
- When undefined: misaligned requests are split into two accesses as described above. err flags illegal Funct3 only.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_t;
  - Funct3 localparams F3_LB/LH/LW/LBU/LHU/SB/SH/SW;
  - function size_of(funct3) returning 1, 2 or 4;
  - function misaligned(addr_lo, funct3).
- One sub-module, load_extend: combinational, taking a 64-bit {hi,lo} window, offset and Funct3, and producing the extended 32-bit rd.

Test Plan:
- Aligned LW: addr=0x010 with mem word 0xDEADBEEF -> mem_re in ACC1 only, rsp_valid at accept+3, rd=0xDEADBEEF, err=0.
- LB / LBU: addr=0x013 with word 0x80FF7F01 -> LB gives rd=0xFFFFFF80; LBU gives 0x00000080. Single access in both cases.
- Split LW: addr=0x00E with words 0x11223344 at 0x00C and 0x55667788 at 0x010 -> accesses at 0x00C then 0x010, rd=0x77881122, rsp_valid at accept+4, stall high for 4 cycles.
- Split SH with wrap: addr=0x1FF, wd=0x0000ABCD -> first access mem_addr=0x1FC with mem_we=1000 (lane 3 gets 0xCD); second access mem_addr=0x000 with mem_we=0001 (lane 0 gets 0xAB).
- Illegal/trap cases:
  - Funct3=011 load -> rsp_valid at accept+1, err=1, mem_re never asserted.
  - With LSU_MISALIGN_TRAP_EN defined, LW addr=0x002 -> err=1, no access.
- Reset in ACC2 of a split store -> mem_we=0 next cycle, state IDLE, no rsp_valid, and a following aligned SW at 0x020 completes normally.
